// File: rtl/hour_set_ctrl.sv
// -----------------------------------------------------------------------------
// hour_set_ctrl
//
// Control stage in front of the two hour digit counters of the alarm clock.
// It issues one-cycle LD/IN/Up/Enable commands to the hour-tens (0-1) counter
// and the hour-units (BCD) counter. It also reads both counter values back so
// that the hours follow 12,1,...,11,12, and it pulses the AM/PM flag on the
// 11->12 step. A button-driven SET mode debounces Set/Inc, steps once on an Inc
// press, and auto-repeats while Inc is held.
//
// Ports
//   Clk        system clock, rising edge
//   Clr        synchronous active-high reset
//   Tick       one-cycle hour carry from the minute stage
//   Btn_Set    raw asynchronous Set button (active high)
//   Btn_Inc    raw asynchronous Inc button (active high)
//   HT_Q       hour-tens counter value
//   HU_Q       hour-units counter value
//   HT_LD, HT_IN_0, HT_Up, HT_Enable   hour-tens command pulses
//   HU_LD, HU_IN, HU_Up, HU_Enable     hour-units command pulses
//   PM_Toggle  one-cycle pulse flipping the AM/PM flag
//   Setting    high while in SET mode (display blink)
//
// States
//   S_RUN        | normal timekeeping, Tick requests a step
//   S_SET_IDLE   | SET mode, waiting for an Inc press
//   S_SET_HOLD   | Inc held after its first step, counting towards auto-repeat
//   S_SET_REPEAT | auto-repeat, one step every REPEAT_CYCLES
// -----------------------------------------------------------------------------
module hour_set_ctrl #(
    parameter int DEB_CYCLES    = 4,
    parameter int HOLD_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 4,
    parameter int CW            = 16
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic       Tick,
    input  logic       Btn_Set,
    input  logic       Btn_Inc,
    input  logic       HT_Q,
    input  logic [3:0] HU_Q,
    output logic       HT_LD,
    output logic       HT_IN_0,
    output logic       HT_Up,
    output logic       HT_Enable,
    output logic       HU_LD,
    output logic [3:0] HU_IN,
    output logic       HU_Up,
    output logic       HU_Enable,
    output logic       PM_Toggle,
    output logic       Setting
);

    // Degenerate parameter values are clamped so every timer still terminates.
    // A repeat period below 2 would collide with the pulse + settle window.
    localparam int DEB_EFF  = (DEB_CYCLES < 1)    ? 1 : DEB_CYCLES;
    localparam int HOLD_EFF = (HOLD_CYCLES < 1)   ? 1 : HOLD_CYCLES;
    localparam int REP_EFF  = (REPEAT_CYCLES < 2) ? 2 : REPEAT_CYCLES;

    localparam logic [CW-1:0] DEB_TC  = CW'(DEB_EFF - 1);
    localparam logic [CW-1:0] HOLD_TC = CW'(HOLD_EFF);
    localparam logic [CW-1:0] REP_TC  = CW'(REP_EFF);

    localparam int BTN_SET = 0;
    localparam int BTN_INC = 1;

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_SET_IDLE   = 2'd1,
        S_SET_HOLD   = 2'd2,
        S_SET_REPEAT = 2'd3
    } state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    // -------------------------------------------------------------------------
    // Button conditioning: 2-FF synchronizer followed by a stability counter.
    // -------------------------------------------------------------------------
    logic [1:0]    btn_raw;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    deb_q;
    logic [CW-1:0] deb_cnt_q [2];
    logic [1:0]    press;

    assign btn_raw[BTN_SET] = Btn_Set;
    assign btn_raw[BTN_INC] = Btn_Inc;

    always_ff @(posedge Clk) begin
        if (Clr) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] >= DEB_TC) begin
                    deb_q[i]     <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= sat_inc(deb_cnt_q[i]);
                end
            end
        end
    end

    // The press is flagged on the same edge that raises the debounced level,
    // so the FSM reacts without an extra edge-detect cycle.
    always_comb begin
        press = '0;
        for (int i = 0; i < 2; i++) begin
            press[i] = sync2_q[i] & ~deb_q[i] & (deb_cnt_q[i] >= DEB_TC);
        end
    end

    logic set_press;
    logic inc_press;
    logic inc_level;

    assign set_press = press[BTN_SET];
    assign inc_press = press[BTN_INC];
    assign inc_level = deb_q[BTN_INC];

    // -------------------------------------------------------------------------
    // Mode FSM
    // -------------------------------------------------------------------------
    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] tmr_q;
    logic [CW-1:0] tmr_d;
    logic [CW-1:0] tmr_inc;
    logic          step_req;

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q <= S_RUN;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        step_req = 1'b0;
        tmr_inc  = sat_inc(tmr_q);
        case (state_q)
            S_RUN: begin
                // A Tick in the same cycle as a Set press is still honoured.
                step_req = Tick;
                if (set_press) begin
                    state_d = S_SET_IDLE;
                end
            end
            S_SET_IDLE: begin
                if (set_press) begin
                    state_d = S_RUN;
                end else if (inc_press) begin
                    step_req = 1'b1;
                    state_d  = S_SET_HOLD;
                    tmr_d    = '0;
                end
            end
            S_SET_HOLD: begin
                if (set_press) begin
                    state_d = S_RUN;
                end else if (!inc_level) begin
                    state_d = S_SET_IDLE;
                end else if (tmr_inc >= HOLD_TC) begin
                    state_d = S_SET_REPEAT;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            S_SET_REPEAT: begin
                if (set_press) begin
                    state_d = S_RUN;
                end else if (!inc_level) begin
                    state_d = S_SET_IDLE;
                end else if (tmr_inc >= REP_TC) begin
                    step_req = 1'b1;
                    tmr_d    = '0;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    assign Setting = (state_q != S_RUN);

    // -------------------------------------------------------------------------
    // Step decode from the current counter feedback.
    // -------------------------------------------------------------------------
    logic       d_ht_ld;
    logic       d_ht_in_0;
    logic       d_ht_up;
    logic       d_ht_en;
    logic       d_hu_ld;
    logic [3:0] d_hu_in;
    logic       d_hu_up;
    logic       d_hu_en;
    logic       d_pm;
    logic       fb_invalid;

    assign fb_invalid = HT_Q ? (HU_Q > 4'd2) : ((HU_Q == 4'd0) || (HU_Q > 4'd9));

    always_comb begin
        d_ht_ld   = 1'b0;
        d_ht_in_0 = 1'b0;
        d_ht_up   = 1'b0;
        d_ht_en   = 1'b0;
        d_hu_ld   = 1'b0;
        d_hu_in   = 4'd0;
        d_hu_up   = 1'b0;
        d_hu_en   = 1'b0;
        d_pm      = 1'b0;
        if (fb_invalid) begin
            // Recover to 12 without touching AM/PM.
            d_ht_ld   = 1'b1;
            d_ht_in_0 = 1'b1;
            d_ht_en   = 1'b1;
            d_hu_ld   = 1'b1;
            d_hu_in   = 4'd2;
            d_hu_en   = 1'b1;
        end else if (!HT_Q && HU_Q == 4'd9) begin
            d_hu_ld = 1'b1;
            d_hu_en = 1'b1;
            d_ht_up = 1'b1;
            d_ht_en = 1'b1;
        end else if (HT_Q && HU_Q == 4'd1) begin
            d_hu_up = 1'b1;
            d_hu_en = 1'b1;
            d_pm    = 1'b1;
        end else if (HT_Q && HU_Q == 4'd2) begin
            d_ht_ld = 1'b1;
            d_ht_en = 1'b1;
            d_hu_ld = 1'b1;
            d_hu_in = 4'd1;
            d_hu_en = 1'b1;
        end else begin
            d_hu_up = 1'b1;
            d_hu_en = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Step issue with busy guard.
    // busy_q: 2 = pulse cycle, 1 = settle cycle, 0 = idle. A request seen during
    // the pulse cycle is parked in pend_q and fires at the end of the settle
    // cycle. A request seen during the settle cycle fires at that same point, so
    // the feedback sampled there is always post-update. Anything beyond one
    // outstanding request is dropped.
    // -------------------------------------------------------------------------
    logic [1:0] busy_q;
    logic       pend_q;
    logic       issue;

    assign issue = (busy_q != 2'd2) && (step_req || pend_q);

    always_ff @(posedge Clk) begin
        if (Clr) begin
            busy_q    <= 2'd0;
            pend_q    <= 1'b0;
            HT_LD     <= 1'b0;
            HT_IN_0   <= 1'b0;
            HT_Up     <= 1'b0;
            HT_Enable <= 1'b0;
            HU_LD     <= 1'b0;
            HU_IN     <= 4'd0;
            HU_Up     <= 1'b0;
            HU_Enable <= 1'b0;
            PM_Toggle <= 1'b0;
        end else if (issue) begin
            busy_q    <= 2'd2;
            pend_q    <= 1'b0;
            HT_LD     <= d_ht_ld;
            HT_IN_0   <= d_ht_in_0;
            HT_Up     <= d_ht_up;
            HT_Enable <= d_ht_en;
            HU_LD     <= d_hu_ld;
            HU_IN     <= d_hu_in;
            HU_Up     <= d_hu_up;
            HU_Enable <= d_hu_en;
            PM_Toggle <= d_pm;
        end else begin
            HT_LD     <= 1'b0;
            HT_IN_0   <= 1'b0;
            HT_Up     <= 1'b0;
            HT_Enable <= 1'b0;
            HU_LD     <= 1'b0;
            HU_IN     <= 4'd0;
            HU_Up     <= 1'b0;
            HU_Enable <= 1'b0;
            PM_Toggle <= 1'b0;
            if (busy_q != 2'd0) begin
                busy_q <= busy_q - 2'd1;
            end
            if (busy_q == 2'd2 && step_req) begin
                pend_q <= 1'b1;
            end
        end
    end

endmodule
